// File: rtl/booth_mult_if.sv
// Start/done handshake and operand/product bus between the control unit and booth_mult.
interface booth_mult_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output hi,
    output lo
  );
endinterface

// File: rtl/booth_mult.sv
// Sequential 32x32 signed radix-2 Booth multiplier, one recoding step per clock.
// Produces the full 64-bit product for the HI/LO registers.
module booth_mult (
  input  logic         clk,
  input  logic         reset,
  booth_mult_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [32:0] m_q, m_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        q1_q, q1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [32:0] sum;

  // 33-bit accumulator keeps A-M exact when the multiplicand is -2^31.
  always_comb begin
    unique case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d     = {bus.a[31], bus.a};
          acc_d   = '0;
          q_d     = bus.b;
          q1_d    = 1'b0;
          cnt_d   = 6'd32;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Arithmetic right shift of {A,Q,q_1}, replicating the accumulator sign.
        acc_d = {sum[32], sum[32:1]};
        q_d   = {sum[0], q_q[31:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          hi_d    = acc_d[31:0];
          lo_d    = q_d;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StCalc);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_mult.sv
// Directed self-checking bench for booth_mult: products, latency, handshake and reset abort.
module tb_booth_mult;

  logic clk;
  logic reset;
  booth_mult_if bus ();

  booth_mult dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned overlap  = 0;
  logic [63:0] last_prod;

  always @(negedge clk) begin
    if (bus.busy && bus.done) overlap++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Accepts one operation and checks latency, busy width, hold of hi/lo and the product.
  // poke=1 pulses a competing start mid-run and scrambles the operand inputs.
  task automatic do_mult(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] exp, input bit poke);
    int n;
    int busy_n;
    int hold_bad;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    n = 0;
    busy_n = 0;
    hold_bad = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_n++;
      if ({bus.hi, bus.lo} !== last_prod) hold_bad++;
      if (poke && n == 10) begin
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
      end
      if (poke && n == 11) begin
        bus.start = 1'b0;
        bus.a     = 32'hdead_beef;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, " latency"}, 64'(n), 64'd32);
    check_eq({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
    check_eq({tag, " hold"}, 64'(hold_bad), 64'd0);
    check_eq({tag, " product"}, {bus.hi, bus.lo}, exp);
    check_eq({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    last_prod = exp;
    if (!poke) begin
      @(posedge clk);
      #1;
      check_eq({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int n;
    int done_seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    last_prod = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_prod", {bus.hi, bus.lo}, 64'd0);
    check_eq("rst_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("idle_prod", {bus.hi, bus.lo}, 64'd0);
    check_eq("idle_flags", {62'd0, bus.busy, bus.done}, 64'd0);

    do_mult("3x5",     32'd3,         32'd5,         64'h0000_0000_0000_000F, 1'b0);
    do_mult("m3x5",    32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    do_mult("5xm3",    32'd5,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    do_mult("min_sq",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    do_mult("max_sq",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
    do_mult("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0);
    do_mult("m1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    do_mult("zero",    32'd0,         32'h8000_0000, 64'h0000_0000_0000_0000, 1'b0);

    // Competing starts during CALC and DONE; then a held start produces 7x7.
    do_mult("poke3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
    bus.start = 1'b1;
    bus.a     = 32'd7;
    bus.b     = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("7x7 done_seen", 64'(bus.done), 64'd1);
    check_eq("7x7 product", {bus.hi, bus.lo}, 64'd49);
    @(posedge clk);
    #1;

    // Reset abort mid-CALC after a completed result.
    last_prod = 64'd49;
    do_mult("pre_rst", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    bus.start = 1'b1;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_prod", {bus.hi, bus.lo}, 64'd0);
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    last_prod = '0;
    do_mult("2xm4", 32'd2, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);

    check_eq("busy_done_overlap", 64'(overlap), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
